// File: rtl/switch_input_ctrl_if.sv
// CPU-side bus for the slide-switch input block.
// The CPU drives chip select, read strobe and word address, and the block returns registered read data.
interface switch_input_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              switchcs;
    logic              switchread;
    logic [1:0]        switchaddr;
    logic [DATA_W-1:0] switchrdata;

    modport master (
        output switchcs,
        output switchread,
        output switchaddr,
        input  switchrdata
    );

    modport slave (
        input  switchcs,
        input  switchread,
        input  switchaddr,
        output switchrdata
    );
endinterface

// File: rtl/switch_input_ctrl.sv
// Slide-switch input block.
// Each switch is synchronised and debounced independently. Debounced levels are mirrored on
// sw_level, and sticky rising-edge flags feed an interrupt level. The CPU reads levels or flags
// through a registered read port. Reading a flag word clears the bits it returned, but a
// coinciding new event still wins.
module switch_input_ctrl #(
    parameter int NUM_SW     = 24,
    parameter int DATA_W     = 16,
    parameter int DEB_CYCLES = 20000,
    parameter int CNT_W      = $clog2(DEB_CYCLES + 1)
) (
    input  logic                switclk,
    input  logic                switrst,
    switch_input_ctrl_if.slave  cpuBus,
    input  logic [NUM_SW-1:0]   switch_i,
    output logic [NUM_SW-1:0]   sw_level,
    output logic                switch_irq
);

    localparam int               WIDE_W   = 2 * DATA_W;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [NUM_SW-1:0]            sync1_q;
    logic [NUM_SW-1:0]            sync2_q;
    logic [NUM_SW-1:0]            deb_q;
    logic [NUM_SW-1:0]            deb_d;
    logic [NUM_SW-1:0][CNT_W-1:0] cnt_q;
    logic [NUM_SW-1:0][CNT_W-1:0] cnt_d;
    logic [NUM_SW-1:0]            flag_q;
    logic [NUM_SW-1:0]            flag_d;
    logic [NUM_SW-1:0]            riseEvent;
    logic [NUM_SW-1:0]            clearMask;
    logic [DATA_W-1:0]            rdata_q;
    logic [DATA_W-1:0]            rdata_d;
    logic                         irq_q;
    logic                         irq_d;
    logic [WIDE_W-1:0]            debWide;
    logic [WIDE_W-1:0]            flagWide;
    logic                         readHit;

    // Per-channel debounce: count consecutive disagreeing clocks and flip once the run is long enough.
    always_comb begin
        deb_d     = deb_q;
        cnt_d     = cnt_q;
        riseEvent = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DEB_LAST) begin
                deb_d[i]     = ~deb_q[i];
                cnt_d[i]     = '0;
                riseEvent[i] = ~deb_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Read decode, read-to-clear of flag words (new events take priority) and interrupt level.
    always_comb begin
        readHit                 = cpuBus.switchcs && cpuBus.switchread;
        debWide                 = '0;
        debWide[NUM_SW-1:0]     = deb_q;
        flagWide                = '0;
        flagWide[NUM_SW-1:0]    = flag_q;
        rdata_d                 = rdata_q;
        if (readHit) begin
            case (cpuBus.switchaddr)
                2'b00:   rdata_d = debWide[DATA_W-1:0];
                2'b10:   rdata_d = debWide[WIDE_W-1:DATA_W];
                2'b01:   rdata_d = flagWide[DATA_W-1:0];
                default: rdata_d = flagWide[WIDE_W-1:DATA_W];
            endcase
        end
        clearMask = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            clearMask[i] = readHit && cpuBus.switchaddr[0] && (cpuBus.switchaddr[1] == (i >= DATA_W));
        end
        flag_d = (flag_q & ~clearMask) | riseEvent;
        irq_d  = |flag_d;
    end

    // State registers with synchronous reset clearing everything, including the synchroniser.
    always_ff @(posedge switclk) begin
        if (switrst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            cnt_q   <= '0;
            flag_q  <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            sync1_q <= switch_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign cpuBus.switchrdata = rdata_q;
    assign sw_level           = deb_q;
    assign switch_irq         = irq_q;

endmodule
